write_merge_buffer: RTL and testbench
=====================================

WRITE_MERGE_BUFFER -- requirements
Module: write_merge_buffer

Interface
REQ-001 The module SHALL have parameter LINE_BYTES, default 16, giving the cache line size in bytes (power of two, at least 2).
REQ-002 The module SHALL have parameter WORD_BYTES, default 2, giving the store width in bytes (power of two, at most LINE_BYTES).
REQ-003 The module SHALL have parameter ADDR_W, default 16, giving the byte address width.
REQ-004 The module SHALL have parameter TIMEOUT, default 8, giving the idle cycles before an automatic drain; 0 disables the timeout.
REQ-005 The module SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The module SHALL have `st_valid`, input, 1 bit: a store request is present.
REQ-008 The module SHALL have `st_ready`, output, 1 bit: the buffer accepts the store this cycle.
REQ-009 The module SHALL have `st_addr`, input, ADDR_W bits: the store byte address.
REQ-010 The module SHALL have `st_wdata`, input, WORD_BYTES*8 bits: the store data, word-aligned lanes.
REQ-011 The module SHALL have `st_be`, input, WORD_BYTES bits: per-byte enables within the word.
REQ-012 The module SHALL have `flush`, input, 1 bit: a request to drain the buffered line.
REQ-013 The module SHALL have `wb_valid`, output, 1 bit: a merged line is offered to the cache.
REQ-014 The module SHALL have `wb_ready`, input, 1 bit: the cache accepts the line.
REQ-015 The module SHALL have `wb_line_addr`, output, ADDR_W-log2(LINE_BYTES) bits: the line address.
REQ-016 The module SHALL have `wb_data`, output, LINE_BYTES*8 bits: the merged line data.
REQ-017 The module SHALL have `wb_mask`, output, LINE_BYTES bits: the written-byte mask.
REQ-018 The module SHALL have `busy`, output, 1 bit: high whenever the state is not EMPTY.

Function
REQ-019 The FSM SHALL have exactly three states: EMPTY, MERGE and DRAIN.
REQ-020 A store SHALL be accepted only on a cycle with st_valid=1 and st_ready=1.
REQ-021 st_ready SHALL be 1 in EMPTY, and 1 in MERGE only when flush=0 and st_addr's line equals the buffered line; otherwise it SHALL be 0.
REQ-022 Placement rule: word index = st_addr[log2(LINE_BYTES)-1:log2(WORD_BYTES)]; store byte i SHALL be written to line byte word_index*WORD_BYTES+i when st_be[i]=1, and those mask bits set; st_addr bits below log2(WORD_BYTES) are ignored.
REQ-023 Other bytes SHALL keep their value; a later store to an already-written byte SHALL overwrite it.
REQ-024 A store accepted in EMPTY SHALL capture the line address, clear the data and mask before merging, and move to MERGE next cycle.
REQ-025 In MERGE, a store whose merge makes wb_mask all-ones SHALL cause a transition to DRAIN on the next cycle.
REQ-026 In MERGE, flush=1 SHALL cause DRAIN next cycle; flush wins over a same-cycle store.
REQ-027 In MERGE, st_valid=1 with a different line SHALL cause DRAIN next cycle; that store stays pending and is not accepted.
REQ-028 The idle counter SHALL clear on each accepted store and increment every MERGE cycle without one.
REQ-029 When the idle counter reaches TIMEOUT (TIMEOUT>0), the FSM SHALL move to DRAIN next cycle.
REQ-030 wb_valid SHALL equal (state==DRAIN).
REQ-031 wb_line_addr, wb_data and wb_mask SHALL stay stable while wb_valid=1 and wb_ready=0.
REQ-032 A wb_valid and wb_ready handshake SHALL return the FSM to EMPTY next cycle with the mask cleared.
REQ-033 flush in EMPTY SHALL be a no-op, and no zero-mask line SHALL ever be issued.
REQ-034 wb_ready SHALL be ignored outside DRAIN.

Reset
REQ-035 While rst_n=0 (asynchronous), the state SHALL be EMPTY and the line address, data, mask and idle counter SHALL be 0.
REQ-036 While rst_n=0, wb_valid and busy SHALL be 0 and st_ready SHALL be 1 after release.
REQ-037 A reset during DRAIN SHALL discard the line, with wb_valid dropping immediately without waiting for a clock edge.

Structure
REQ-038 Package wmb_pkg SHALL hold the state enum (EMPTY/MERGE/DRAIN) and the default parameter constants.
REQ-039 The combinational byte placement SHALL be the sub-module byte_lane_merge, parametrised by LINE_BYTES and WORD_BYTES; the FSM, registers and counter SHALL stay in the top.

Verification (LINE_BYTES=16, WORD_BYTES=2, ADDR_W=16, TIMEOUT=8)
REQ-040 Store 0x0104/0xBEEF/be=11, then 0x010E/0x12xx/be=10, then flush -> wb_line_addr=0x010, bytes 4,5=EF,BE, byte 15=0x12, wb_mask=0x8030.
REQ-041 Store 0x0100/0x0011/be=01, then 0x0100/0x0022/be=01, then flush -> byte 0=0x22, wb_mask=0x0001.
REQ-042 Store 0x0100, then st_valid at 0x0200 -> st_ready=0; line 0x010 is drained; after wb_ready the 0x0200 store is accepted in EMPTY.
REQ-043 Eight be=11 stores to 0x0100..0x010E -> wb_mask=0xFFFF and wb_valid=1 the cycle after the 8th store, with no flush.
REQ-044 One store then idle -> DRAIN after 8 idle cycles; wb_ready held 0 for 5 cycles -> outputs unchanged.
REQ-045 rst_n=0 while wb_valid=1 -> wb_valid=0 and wb_mask=0 immediately; after release a new store is accepted.

Source files
------------

// File: rtl/wmb_pkg.sv
// Shared types and default configuration for the write merge buffer.
package wmb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MERGE = 2'd1,
        DRAIN = 2'd2
    } wmb_state_e;

    localparam int unsigned DEF_LINE_BYTES = 16;
    localparam int unsigned DEF_WORD_BYTES = 2;
    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_TIMEOUT    = 8;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational placement of one store word into a cache line image and its byte mask.
module byte_lane_merge #(
    parameter  int unsigned LINE_BYTES = wmb_pkg::DEF_LINE_BYTES,
    parameter  int unsigned WORD_BYTES = wmb_pkg::DEF_WORD_BYTES,
    localparam int unsigned WORDS      = LINE_BYTES / WORD_BYTES,
    localparam int unsigned IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic [LINE_BYTES*8-1:0] line_data_i,
    input  logic [LINE_BYTES-1:0]   line_mask_i,
    input  logic [IDX_W-1:0]        word_idx_i,
    input  logic [WORD_BYTES*8-1:0] wdata_i,
    input  logic [WORD_BYTES-1:0]   be_i,
    output logic [LINE_BYTES*8-1:0] line_data_o,
    output logic [LINE_BYTES-1:0]   line_mask_o
);

    always_comb begin
        line_data_o = line_data_i;
        line_mask_o = line_mask_i;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (word_idx_i == IDX_W'(w)) begin
                for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                    if (be_i[b]) begin
                        line_data_o[(w*WORD_BYTES+b)*8 +: 8] = wdata_i[b*8 +: 8];
                        line_mask_o[w*WORD_BYTES+b]          = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/write_merge_buffer.sv
// Single-line store merge buffer: collects byte stores to one cache line and
// drains the merged line on full mask, flush, line conflict or idle timeout.
module write_merge_buffer
    import wmb_pkg::*;
#(
    parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
    parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 st_valid,
    output logic                                 st_ready,
    input  logic [ADDR_W-1:0]                    st_addr,
    input  logic [WORD_BYTES*8-1:0]              st_wdata,
    input  logic [WORD_BYTES-1:0]                st_be,
    input  logic                                 flush,
    output logic                                 wb_valid,
    input  logic                                 wb_ready,
    output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] wb_line_addr,
    output logic [LINE_BYTES*8-1:0]              wb_data,
    output logic [LINE_BYTES-1:0]                wb_mask,
    output logic                                 busy
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned WOFF_W = $clog2(WORD_BYTES);
    localparam int unsigned WORDS  = LINE_BYTES / WORD_BYTES;
    localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LA_W   = ADDR_W - OFF_W;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    wmb_state_e              state_q, state_d;
    logic [LA_W-1:0]         line_q, line_d;
    logic [LINE_BYTES*8-1:0] data_q, data_d;
    logic [LINE_BYTES-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]        idle_q, idle_d;

    logic [LA_W-1:0]         st_line;
    logic                    line_hit;
    logic [IDX_W-1:0]        word_idx;
    logic [LINE_BYTES*8-1:0] base_data, merged_data;
    logic [LINE_BYTES-1:0]   base_mask, merged_mask;
    logic [CNT_W-1:0]        idle_inc;
    logic                    timeout_hit;
    logic                    unused_addr_bits;

    assign st_line          = st_addr[ADDR_W-1:OFF_W];
    assign line_hit         = (st_line == line_q);
    assign unused_addr_bits = ^st_addr[OFF_W-1:0];

    if (WORDS > 1) begin : g_word_idx
        assign word_idx = st_addr[OFF_W-1:WOFF_W];
    end else begin : g_single_word
        assign word_idx = '0;
    end

    // A store accepted in EMPTY merges onto a cleared line rather than stale data.
    assign base_data = (state_q == EMPTY) ? '0 : data_q;
    assign base_mask = (state_q == EMPTY) ? '0 : mask_q;

    byte_lane_merge #(
        .LINE_BYTES (LINE_BYTES),
        .WORD_BYTES (WORD_BYTES)
    ) u_merge (
        .line_data_i (base_data),
        .line_mask_i (base_mask),
        .word_idx_i  (word_idx),
        .wdata_i     (st_wdata),
        .be_i        (st_be),
        .line_data_o (merged_data),
        .line_mask_o (merged_mask)
    );

    assign idle_inc    = idle_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (idle_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            line_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        data_d   = data_q;
        mask_d   = mask_q;
        idle_d   = idle_q;
        st_ready = 1'b0;
        unique case (state_q)
            EMPTY: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    line_d  = st_line;
                    data_d  = merged_data;
                    mask_d  = merged_mask;
                    idle_d  = '0;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                st_ready = !flush && line_hit;
                if (flush || (st_valid && !line_hit)) begin
                    state_d = DRAIN;
                end else if (st_valid) begin
                    data_d = merged_data;
                    mask_d = merged_mask;
                    idle_d = '0;
                    if (&merged_mask) begin
                        state_d = DRAIN;
                    end
                end else begin
                    idle_d = idle_inc;
                    if (timeout_hit) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wb_ready) begin
                    mask_d  = '0;
                    idle_d  = '0;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign wb_valid     = (state_q == DRAIN);
    assign busy         = (state_q != EMPTY);
    assign wb_line_addr = line_q;
    assign wb_data      = data_q;
    assign wb_mask      = mask_q;

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed self-checking bench for write_merge_buffer (16-byte line, 2-byte store, timeout 8).
module tb_write_merge_buffer;

    logic         clk;
    logic         rst_n;
    logic         st_valid;
    logic         st_ready;
    logic [15:0]  st_addr;
    logic [15:0]  st_wdata;
    logic [1:0]   st_be;
    logic         flush;
    logic         wb_valid;
    logic         wb_ready;
    logic [11:0]  wb_line_addr;
    logic [127:0] wb_data;
    logic [15:0]  wb_mask;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    write_merge_buffer #(
        .LINE_BYTES (16),
        .WORD_BYTES (2),
        .ADDR_W     (16),
        .TIMEOUT    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_wdata     (st_wdata),
        .st_be        (st_be),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_line_addr (wb_line_addr),
        .wb_data      (wb_data),
        .wb_mask      (wb_mask),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_be    = be;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
        flush = 1'b0; wb_ready = 1'b0;
        #12;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wb_mask !== 16'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0000", wb_mask); end
        checks++; if (wb_data !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_data); end
        checks++; if (wb_line_addr !== 12'h0) begin failures++; $display("FAIL reset_line got=%h exp=000", wb_line_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
        do_flush();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_flush_busy got=%b exp=0", busy); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL empty_flush_wb_valid got=%b exp=0", wb_valid); end
    endtask

    task automatic test_merge_flush();
        do_store(16'h0104, 16'hBEEF, 2'b11);
        do_store(16'h010E, 16'h12AB, 2'b10);
        // flush together with a same-line store: flush wins, store not taken
        st_valid = 1'b1; st_addr = 16'h0100; st_wdata = 16'h5555; st_be = 2'b11;
        flush = 1'b1;
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL flush_st_ready got=%b exp=0", st_ready); end
        tick();
        st_valid = 1'b0; flush = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL merge_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_line_addr !== 12'h010) begin failures++; $display("FAIL merge_line got=%h exp=010", wb_line_addr); end
        checks++; if (wb_mask !== 16'h8030) begin failures++; $display("FAIL merge_mask got=%h exp=8030", wb_mask); end
        checks++; if (wb_data !== 128'h1200_0000_0000_0000_0000_BEEF_0000_0000) begin
            failures++; $display("FAIL merge_data got=%h exp=%h", wb_data, 128'h1200_0000_0000_0000_0000_BEEF_0000_0000); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL merge_done_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL merge_done_busy got=%b exp=0", busy); end
        checks++; if (wb_mask !== 16'h0) begin failures++; $display("FAIL merge_done_mask got=%h exp=0000", wb_mask); end
    endtask

    task automatic test_overwrite();
        // wb_ready held high outside DRAIN must have no effect
        wb_ready = 1'b1;
        do_store(16'h0100, 16'h0011, 2'b01);
        do_store(16'h0100, 16'h0022, 2'b01);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovw_busy got=%b exp=1", busy); end
        do_flush();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL ovw_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_mask !== 16'h0001) begin failures++; $display("FAIL ovw_mask got=%h exp=0001", wb_mask); end
        checks++; if (wb_data !== 128'h22) begin failures++; $display("FAIL ovw_data got=%h exp=22", wb_data); end
        tick();
        wb_ready = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL ovw_done_wb_valid got=%b exp=0", wb_valid); end
    endtask

    task automatic test_line_conflict();
        do_store(16'h0100, 16'h00AA, 2'b01);
        st_valid = 1'b1; st_addr = 16'h0200; st_wdata = 16'h3344; st_be = 2'b11;
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL conflict_st_ready got=%b exp=0", st_ready); end
        tick();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL conflict_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_line_addr !== 12'h010) begin failures++; $display("FAIL conflict_line got=%h exp=010", wb_line_addr); end
        checks++; if (wb_mask !== 16'h0001) begin failures++; $display("FAIL conflict_mask got=%h exp=0001", wb_mask); end
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL drain_st_ready got=%b exp=0", st_ready); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL conflict_empty_st_ready got=%b exp=1", st_ready); end
        tick();
        st_valid = 1'b0;
        do_flush();
        checks++; if (wb_line_addr !== 12'h020) begin failures++; $display("FAIL pending_line got=%h exp=020", wb_line_addr); end
        checks++; if (wb_mask !== 16'h0003) begin failures++; $display("FAIL pending_mask got=%h exp=0003", wb_mask); end
        checks++; if (wb_data !== 128'h3344) begin failures++; $display("FAIL pending_data got=%h exp=3344", wb_data); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_full_line();
        for (int k = 0; k < 8; k++) begin
            do_store(16'h0100 + 16'(2*k), {8'(2*k+1), 8'(2*k)}, 2'b11);
            if (k == 6) begin
                checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL full_early_wb_valid got=%b exp=0", wb_valid); end
            end
        end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL full_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_mask !== 16'hFFFF) begin failures++; $display("FAIL full_mask got=%h exp=ffff", wb_mask); end
        checks++; if (wb_data !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
            failures++; $display("FAIL full_data got=%h exp=%h", wb_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_store(16'h0300, 16'h7700, 2'b10);
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL idle_%0d_wb_valid got=%b exp=0", i, wb_valid); end
        end
        tick();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL timeout_wb_valid got=%b exp=1", wb_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL stall_%0d_wb_valid got=%b exp=1", i, wb_valid); end
            checks++; if (wb_line_addr !== 12'h030) begin failures++; $display("FAIL stall_%0d_line got=%h exp=030", i, wb_line_addr); end
            checks++; if (wb_mask !== 16'h0002) begin failures++; $display("FAIL stall_%0d_mask got=%h exp=0002", i, wb_mask); end
            checks++; if (wb_data !== 128'h7700) begin failures++; $display("FAIL stall_%0d_data got=%h exp=7700", i, wb_data); end
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_done_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_in_drain();
        do_store(16'h0500, 16'h00CC, 2'b01);
        do_flush();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL rstdrain_pre_wb_valid got=%b exp=1", wb_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstdrain_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_mask !== 16'h0) begin failures++; $display("FAIL rstdrain_mask got=%h exp=0000", wb_mask); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstdrain_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        st_valid = 1'b1; st_addr = 16'h0400; st_wdata = 16'h0099; st_be = 2'b01;
        #1;
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL rstdrain_st_ready got=%b exp=1", st_ready); end
        tick();
        st_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstdrain_accept_busy got=%b exp=1", busy); end
        do_flush();
        checks++; if (wb_line_addr !== 12'h040) begin failures++; $display("FAIL rstdrain_line got=%h exp=040", wb_line_addr); end
        checks++; if (wb_mask !== 16'h0001) begin failures++; $display("FAIL rstdrain_new_mask got=%h exp=0001", wb_mask); end
        checks++; if (wb_data !== 128'h99) begin failures++; $display("FAIL rstdrain_new_data got=%h exp=99", wb_data); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_merge_flush();
        test_overwrite();
        test_line_conflict();
        test_full_line();
        test_timeout();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
